// File: rtl/pe_sum_collector.sv
// Bottom-of-array sum collector: deskews PE column sums, accumulates per row across
// K-tiles and queues finished rows in a first-word-fall-through FIFO for writeback.
module pe_sum_collector #(
    parameter int unsigned data_width         = 20,
    parameter int unsigned a_tile_row_size    = 16,
    parameter int unsigned w_tile_column_size = 2,
    parameter int unsigned acc_width          = 48,
    parameter int unsigned fifo_depth         = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    input  logic                                         in_first,
    input  logic                                         in_last,
    input  logic [2*data_width*w_tile_column_size-1:0]   in_sum,
    output logic                                         in_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [acc_width*w_tile_column_size-1:0]      out_data,
    output logic [$clog2(a_tile_row_size)-1:0]           out_row,
    output logic                                         busy,
    output logic                                         err_ovf
);

    localparam int unsigned COLS   = w_tile_column_size;
    localparam int unsigned SW     = 2 * data_width;
    localparam int unsigned ROWS   = a_tile_row_size;
    localparam int unsigned ROW_W  = $clog2(a_tile_row_size);
    localparam int unsigned PIPE   = COLS - 1;
    localparam int unsigned DLY_W  = (COLS - 1) * SW;
    localparam int unsigned OUT_W  = acc_width * COLS;
    localparam int unsigned PTR_W  = $clog2(fifo_depth);
    localparam int unsigned CNT_W  = $clog2(fifo_depth + 1);
    localparam int unsigned THRESH = fifo_depth - a_tile_row_size;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [OUT_W-1:0] data;
    } entry_t;

    logic [PIPE-1:0]            vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
    logic [PIPE-1:0][DLY_W-1:0] dat_q, dat_d;
    logic [OUT_W-1:0]           acc_q [ROWS];
    logic [OUT_W-1:0]           acc_d [ROWS];
    logic [ROW_W-1:0]           row_q, row_d;
    entry_t                     mem_q [fifo_depth];
    entry_t                     mem_d [fifo_depth];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d, pending_q, pending_d;
    logic [CNT_W:0]             occ;
    entry_t                     head_q, head_d, new_entry;
    logic                       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                       busy_q, busy_d, err_ovf_q, err_ovf_d;

    logic                       d_valid, d_first, d_last;
    logic [OUT_W-1:0]           acc_row, push_data;
    logic                       push, pop, full, push_ok;

    assign d_valid = vld_q[PIPE-1];
    assign d_first = fst_q[PIPE-1];
    assign d_last  = lst_q[PIPE-1];
    assign acc_row = acc_q[row_q];

    // Per-column alignment, sign extension and accumulate/overwrite
    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [SW-1:0]        slice;
        logic [acc_width-1:0] ext;
        if (j == COLS - 1) begin : g_direct
            assign slice = in_sum[j*SW +: SW];
        end else begin : g_delayed
            assign slice = dat_q[PIPE-1-j][j*SW +: SW];
        end
        assign ext = acc_width'($signed(slice));
        assign push_data[j*acc_width +: acc_width] =
            d_first ? ext : acc_row[j*acc_width +: acc_width] + ext;
    end

    always_comb begin
        vld_d     = PIPE'({vld_q, in_valid});
        fst_d     = PIPE'({fst_q, in_first});
        lst_d     = PIPE'({lst_q, in_last});
        dat_d     = (PIPE*DLY_W)'({dat_q, in_sum[DLY_W-1:0]});
        acc_d     = acc_q;
        row_d     = row_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        head_d    = head_q;
        new_entry = '{row: row_q, data: push_data};

        push    = d_valid && d_last;
        pop     = out_valid_q && out_ready;
        full    = (count_q == CNT_W'(fifo_depth));
        push_ok = push && (!full || pop);

        if (d_valid) begin
            acc_d[row_q] = push_data;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d = (wr_ptr_q == PTR_W'(fifo_depth - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(fifo_depth - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        pending_d = pending_q + CNT_W'(in_valid && in_last) - CNT_W'(d_valid && d_last);
        occ       = (CNT_W+1)'(count_d) + (CNT_W+1)'(pending_d);

        // Head register mirrors the entry at the next read pointer
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                head_d = new_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        in_ready_d  = (occ <= (CNT_W+1)'(THRESH));
        out_valid_d = (count_d != '0);
        busy_d      = (row_d != '0) || (|vld_d);
        err_ovf_d   = err_ovf_q || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            fst_q       <= '0;
            lst_q       <= '0;
            dat_q       <= '0;
            for (int i = 0; i < ROWS; i++) acc_q[i] <= '0;
            for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
            row_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            head_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            fst_q       <= fst_d;
            lst_q       <= lst_d;
            dat_q       <= dat_d;
            acc_q       <= acc_d;
            mem_q       <= mem_d;
            row_q       <= row_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            head_q      <= head_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q.data;
    assign out_row   = head_q.row;
    assign busy      = busy_q;
    assign err_ovf   = err_ovf_q;

endmodule
